fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC, issues one instruction-memory read at a time and presents
//  the fetched instruction to decode through the IF/ID register. Freezes while the hazard controller

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and feeds decode
// through the IF/ID register, with a one-entry skid for responses that land during a stall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        isDataHazard,
   input  logic        brTaken,
   input  logic [31:0] brTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemRdata,
   output logic        ifValid,
   output logic [31:0] ifPc,
   output logic [31:0] ifInsn
);

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      FULL,
      DROP
   } fetchState_t;

   fetchState_t stateQ, stateD;
   logic [31:0] pcQ, pcD;
   logic        ifValidQ, ifValidD;
   logic [31:0] ifPcQ, ifPcD;
   logic [31:0] ifInsnQ, ifInsnD;
   logic        skidValidQ, skidValidD;
   logic [31:0] skidPcQ, skidPcD;
   logic [31:0] skidInsnQ, skidInsnD;
   logic        ifFree;

   assign imemReq  = rstN && (stateQ == FETCH) && !brTaken;
   assign imemAddr = pcQ;
   assign ifValid  = ifValidQ;
   assign ifPc     = ifPcQ;
   assign ifInsn   = ifInsnQ;

   // IF/ID can accept a new instruction when it is empty or decode drains it this edge.
   assign ifFree = !ifValidQ || !isDataHazard;

   always_comb begin
      stateD     = stateQ;
      pcD        = pcQ;
      ifValidD   = ifValidQ;
      ifPcD      = ifPcQ;
      ifInsnD    = ifInsnQ;
      skidValidD = skidValidQ;
      skidPcD    = skidPcQ;
      skidInsnD  = skidInsnQ;

      if (ifValidQ && !isDataHazard) begin
         ifValidD = 1'b0;
         ifInsnD  = NOP_INSN;
      end

      unique case (stateQ)
         FETCH: begin
            if (imemReq) stateD = WAIT;
         end
         WAIT: begin
            if (imemValid) begin
               if (ifFree) begin
                  ifValidD = 1'b1;
                  ifPcD    = pcQ;
                  ifInsnD  = imemRdata;
                  pcD      = pcQ + 32'd4;
                  stateD   = FETCH;
               end else begin
                  skidValidD = 1'b1;
                  skidPcD    = pcQ;
                  skidInsnD  = imemRdata;
                  stateD     = FULL;
               end
            end
         end
         FULL: begin
            if (!isDataHazard) begin
               ifValidD   = 1'b1;
               ifPcD      = skidPcQ;
               ifInsnD    = skidInsnQ;
               skidValidD = 1'b0;
               pcD        = pcQ + 32'd4;
               stateD     = FETCH;
            end
         end
         DROP: begin
            if (imemValid) stateD = FETCH;
         end
         default: stateD = FETCH;
      endcase

      // A redirect wins over everything; a read still in flight must be swallowed in DROP.
      if (brTaken) begin
         pcD        = brTarget & ~32'h3;
         ifValidD   = 1'b0;
         ifInsnD    = NOP_INSN;
         skidValidD = 1'b0;
         if ((stateQ == WAIT || stateQ == DROP) && !imemValid) stateD = DROP;
         else stateD = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         stateQ     <= FETCH;
         pcQ        <= RESET_PC;
         ifValidQ   <= 1'b0;
         ifPcQ      <= 32'h0;
         ifInsnQ    <= NOP_INSN;
         skidValidQ <= 1'b0;
         skidPcQ    <= 32'h0;
         skidInsnQ  <= 32'h0;
      end else begin
         stateQ     <= stateD;
         pcQ        <= pcD;
         ifValidQ   <= ifValidD;
         ifPcQ      <= ifPcD;
         ifInsnQ    <= ifInsnD;
         skidValidQ <= skidValidD;
         skidPcQ    <= skidPcD;
         skidInsnQ  <= skidInsnD;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory by hand and checks
// IF/ID and request outputs against hand-computed values after each step.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstN;
   logic        isDataHazard;
   logic        brTaken;
   logic [31:0] brTarget;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemRdata;
   logic        ifValid;
   logic [31:0] ifPc;
   logic [31:0] ifInsn;

   int testCount = 0;
   int failCount = 0;

   fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSN(NOP)) dut (
      .clk(clk),
      .rstN(rstN),
      .isDataHazard(isDataHazard),
      .brTaken(brTaken),
      .brTarget(brTarget),
      .imemReq(imemReq),
      .imemAddr(imemAddr),
      .imemValid(imemValid),
      .imemRdata(imemRdata),
      .ifValid(ifValid),
      .ifPc(ifPc),
      .ifInsn(ifInsn)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and step 1 time unit past it before touching inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic haz, input logic br,
                                input logic [31:0] tgt, input logic vld, input logic [31:0] data);
      rstN         = rst;
      isDataHazard = haz;
      brTaken      = br;
      brTarget     = tgt;
      imemValid    = vld;
      imemRdata    = data;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      checkOutput("rst_ifValid", {31'b0, ifValid}, 32'h0);
      checkOutput("rst_ifPc", ifPc, 32'h0);
      checkOutput("rst_ifInsn", ifInsn, NOP);
      checkOutput("rst_imemReq", {31'b0, imemReq}, 32'h0);
      checkOutput("rst_imemAddr", imemAddr, 32'h100);

      // first fetch with a 1-cycle memory
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t1_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t1_addr", imemAddr, 32'h100);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
      checkOutput("t1_waitNoReq", {31'b0, imemReq}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t1_ifValid", {31'b0, ifValid}, 32'h1);
      checkOutput("t1_ifPc", ifPc, 32'h100);
      checkOutput("t1_ifInsn", ifInsn, 32'h0050_0093);
      checkOutput("t1_nextReq", {31'b0, imemReq}, 32'h1);
      checkOutput("t1_nextAddr", imemAddr, 32'h104);

      // stall for 5 cycles while the 0x104 response lands in the skid
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00A0_0113);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t2_holdPc", ifPc, 32'h100);
         checkOutput("t2_holdInsn", ifInsn, 32'h0050_0093);
         checkOutput("t2_holdValid", {31'b0, ifValid}, 32'h1);
         checkOutput("t2_noReq", {31'b0, imemReq}, 32'h0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOutput("t2_ifValid", {31'b0, ifValid}, 32'h1);
      checkOutput("t2_ifPc", ifPc, 32'h104);
      checkOutput("t2_ifInsn", ifInsn, 32'h00A0_0113);
      checkOutput("t2_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t2_addr", imemAddr, 32'h108);

      // redirect in WAIT, response for the killed read 3 cycles later
      tick();
      checkOutput("t3_consumed", {31'b0, ifValid}, 32'h0);
      checkOutput("t3_nop", ifInsn, NOP);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t3_dropValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t3_dropNoReq", {31'b0, imemReq}, 32'h0);
      checkOutput("t3_dropAddr", imemAddr, 32'h200);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      checkOutput("t3_dropStillNoReq", {31'b0, imemReq}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t3_discValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t3_discInsn", ifInsn, NOP);
      checkOutput("t3_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t3_addr", imemAddr, 32'h200);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0193);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t3_ifValid", {31'b0, ifValid}, 32'h1);
      checkOutput("t3_ifPc", ifPc, 32'h200);
      checkOutput("t3_ifInsn", ifInsn, 32'h0010_0193);
      checkOutput("t3_nextAddr", imemAddr, 32'h204);

      // skid full, then redirect together with imemValid and a stall
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0020_0213);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h203, 1'b1, 32'hBAD0_0001);
      checkOutput("t4_fullNoReq", {31'b0, imemReq}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t4_ifValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t4_ifInsn", ifInsn, NOP);
      checkOutput("t4_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t4_addr", imemAddr, 32'h200);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'hBAD0_0002);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t4b_ifValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t4b_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t4b_addr", imemAddr, 32'h300);

      // pc wraps from 0xFFFF_FFFC to 0
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      checkOutput("t5_brSuppressReq", {31'b0, imemReq}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t5_addrTop", imemAddr, 32'hFFFF_FFFC);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0293);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t5_ifPc", ifPc, 32'hFFFF_FFFC);
      checkOutput("t5_ifInsn", ifInsn, 32'h0040_0293);
      checkOutput("t5_wrapAddr", imemAddr, 32'h0);

      // reset while a read is outstanding; the stale response must be ignored
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t6_rstNoReq", {31'b0, imemReq}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0003);
      checkOutput("t6_ifValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t6_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t6_addr", imemAddr, 32'h100);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t6_staleValid", {31'b0, ifValid}, 32'h0);
      checkOutput("t6_staleInsn", ifInsn, NOP);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("t6_ifValid2", {31'b0, ifValid}, 32'h1);
      checkOutput("t6_ifPc", ifPc, 32'h100);
      checkOutput("t6_ifInsn", ifInsn, 32'h0050_0093);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
